// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Read side of the 320x240, 3-bit-colour framebuffer. Generates 640x480@60Hz
// VGA timing from the 50 MHz system clock, reads each stored pixel twice per
// line and on two consecutive lines (2x2 doubling), and drives the DE-series
// VGA DAC pins. Also emits a one-clk frame_done pulse once per frame for the
// game logic.
//
// Ports:
//   clk          50 MHz system clock (only clock)
//   reset        asynchronous, active-high reset
//   fb_addr      framebuffer read address, (y/2)*320 + (x/2), 17 bits
//   fb_data      {R,G,B} read data, valid one clk after fb_addr
//   frame_done   one-clk pulse when pixel (H_VIS-1, V_VIS-1) reaches the pins
//   VGA_CLK      25 MHz pixel clock, rising edge mid-pixel
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  low outside the visible area
//   VGA_SYNC_N   tied low
//   VGA_R/G/B    stored colour bit replicated to 10 bits, 0 when blanked
//
// Pipeline (each stage advances on a pixel tick):
//   stage 0: hc/vc counters and combinational vis/hs/vs decode
//   stage 1: fb_addr and delayed vis/hs/vs
//   stage 2: fb_data captured, all VGA pins registered
// The address is presented 2 clk before fb_data is sampled, leaving 1 clk of
// margin over the framebuffer's fixed 1-clk read latency.
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [16:0] fb_addr,
    input  logic [2:0]  fb_data,
    output logic        frame_done,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);

    // pix_tick is 0 on the edge that acts as a pixel tick, so the first edge
    // after reset release is a tick and VGA_CLK (= ~pix_tick) falls as the
    // pins change and rises mid-pixel.
    logic       pix_tick;
    logic       tick;
    logic [9:0] hc;
    logic [9:0] vc;

    assign tick = ~pix_tick;

    // Stage 0 decode
    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic        last0;
    logic [16:0] addr0;

    // Stage 1 delayed copies
    logic vis1;
    logic hs1;
    logic vs1;
    logic last1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_tick <= 1'b0;
            VGA_CLK  <= 1'b1;
        end else begin
            pix_tick <= ~pix_tick;
            VGA_CLK  <= pix_tick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (tick) begin
            if (hc == H_LAST) begin
                hc <= '0;
                if (vc == V_LAST) begin
                    vc <= '0;
                end else begin
                    vc <= vc + 10'd1;
                end
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    // 320 * (vc/2) built as 256*(vc/2) + 64*(vc/2); 17 bits hold the
    // maximum of 239*320 + 319 = 76799 without overflow.
    always_comb begin
        vis0  = (hc < H_VIS_END) && (vc < V_VIS_END);
        hs0   = !((hc >= H_SYNC_BEG) && (hc < H_SYNC_END));
        vs0   = !((vc >= V_SYNC_BEG) && (vc < V_SYNC_END));
        last0 = (hc == H_VIS_LAST) && (vc == V_VIS_LAST);
        addr0 = {1'b0, vc[8:1], 8'b0} + {3'b0, vc[8:1], 6'b0} + {8'b0, hc[9:1]};
    end

    // Stage 1: address held outside the visible area so it never leaves
    // the 0..76799 range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_addr <= '0;
            vis1    <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            last1   <= 1'b0;
        end else if (tick) begin
            if (vis0) begin
                fb_addr <= addr0;
            end
            vis1  <= vis0;
            hs1   <= hs0;
            vs1   <= vs0;
            last1 <= last0;
        end
    end

    // Stage 2: pins. frame_done is written on every edge so it lasts exactly
    // one clk: set on the tick that emits the last visible pixel, cleared on
    // the following non-tick edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= tick & last1;
            if (tick) begin
                VGA_HS      <= hs1;
                VGA_VS      <= vs1;
                VGA_BLANK_N <= vis1;
                VGA_R       <= vis1 ? {10{fb_data[2]}} : 10'd0;
                VGA_G       <= vis1 ? {10{fb_data[1]}} : 10'd0;
                VGA_B       <= vis1 ? {10{fb_data[0]}} : 10'd0;
            end
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// Bench for vga_scanout. Two instances share the clock:
//   u_full  - default 640x480 timing: reset values, line timing, address map
//   u_small - shrunken timing (16x8 visible, 24x14 total) so whole frames,
//             frame_done and a mid-frame reset fit in a short run; a
//             per-sample pixel model checks every pin of this instance.
// Each framebuffer is modelled as fb_data = fb_addr[2:0] with 1-clk latency.
// Edge index k counts posedges after reset release; the stage-0 pixel
// (hc,vc) is ticked into stage 1 at k = 1 + 2*(vc*HT + hc) and reaches the
// pins at k = 3 + 2*(vc*HT + hc).
// ---------------------------------------------------------------------------
module tb_vga_scanout;

    localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 2;
    localparam int S_VV = 8,  S_VF = 2, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 24
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 14

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_full;
    logic rst_small;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT wiring ----------------
    logic [16:0] f_addr, s_addr;
    logic [2:0]  f_data = 3'd0, s_data = 3'd0;
    logic        f_done, f_vclk, f_hs, f_vs, f_blank, f_sync;
    logic        s_done, s_vclk, s_hs, s_vs, s_blank, s_sync;
    logic [9:0]  f_r, f_g, f_b, s_r, s_g, s_b;

    vga_scanout u_full (
        .clk(clk), .reset(rst_full), .fb_addr(f_addr), .fb_data(f_data),
        .frame_done(f_done), .VGA_CLK(f_vclk), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_BLANK_N(f_blank), .VGA_SYNC_N(f_sync),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b)
    );

    vga_scanout #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk(clk), .reset(rst_small), .fb_addr(s_addr), .fb_data(s_data),
        .frame_done(s_done), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
    );

    // Framebuffer models: 1-clk read latency, contents = low address bits.
    always @(posedge clk) begin
        f_data <= f_addr[2:0];
        s_data <= s_addr[2:0];
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_reset_pins(input string who, input logic [16:0] addr, input logic done,
                                    input logic vclk, input logic hs, input logic vs,
                                    input logic blank, input logic sync,
                                    input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        check_val({who, "_addr"},  addr,  0);
        check_val({who, "_done"},  done,  0);
        check_val({who, "_vclk"},  vclk,  1);
        check_val({who, "_hs"},    hs,    1);
        check_val({who, "_vs"},    vs,    1);
        check_val({who, "_blank"}, blank, 0);
        check_val({who, "_sync"},  sync,  0);
        check_val({who, "_rgb"},   {2'b0, r, g, b}, 0);
    endtask

    // ---------------- small-instance pixel model / event recorder ----------------
    bit   s_mon = 1'b0;
    int   s_rel = 0;
    int   s_bad = 0;
    int   s_samples = 0;
    int   s_fd_high = 0;
    int   s_vs_fall_q[$], s_vs_rise_q[$], s_fd_rise_q[$], s_blank_rise_q[$];
    logic s_vs_p = 1'b1, s_fd_p = 1'b0, s_blank_p = 1'b0;

    int       mk, mp, mx, my, ma;
    logic     m_vis, m_hs, m_vs, m_fd, m_vclk;
    logic [2:0] m_col;

    always @(negedge clk) begin
        if (s_mon) begin
            mk = cyc - s_rel;
            if (mk >= 3) begin
                mp     = (mk - 3) / 2;
                mx     = mp % S_HT;
                my     = (mp / S_HT) % S_VT;
                m_vis  = (mx < S_HV) && (my < S_VV);
                ma     = (my / 2) * 320 + (mx / 2);
                m_col  = m_vis ? ma[2:0] : 3'b000;
                m_hs   = !((mx >= S_HV + S_HF) && (mx < S_HV + S_HF + S_HS));
                m_vs   = !((my >= S_VV + S_VF) && (my < S_VV + S_VF + S_VS));
                m_fd   = (mk % 2 == 1) && (mx == S_HV - 1) && (my == S_VV - 1);
                m_vclk = (mk % 2 == 0);
                s_samples++;
                if (s_blank !== m_vis || s_hs !== m_hs || s_vs !== m_vs ||
                    s_done !== m_fd || s_vclk !== m_vclk || s_sync !== 1'b0 ||
                    s_r !== {10{m_col[2]}} || s_g !== {10{m_col[1]}} || s_b !== {10{m_col[0]}})
                    s_bad++;
            end
            if (s_vs_p && !s_vs)        s_vs_fall_q.push_back(mk);
            if (!s_vs_p && s_vs)        s_vs_rise_q.push_back(mk);
            if (!s_fd_p && s_done)      s_fd_rise_q.push_back(mk);
            if (!s_blank_p && s_blank)  s_blank_rise_q.push_back(mk);
            if (s_done)                 s_fd_high++;
        end
        s_vs_p    = s_vs;
        s_fd_p    = s_done;
        s_blank_p = s_blank;
    end

    // ---------------- main sequence ----------------
    logic [16:0] exp_q[$];
    int          exp_edge_q[$];
    int          f_hs_fall_q[$], f_hs_rise_q[$], f_blank_rise_q[$], f_blank_fall_q[$];
    int          f_rel;
    int          k;
    logic        f_hs_p, f_blank_p;

    initial begin
        rst_full  = 1'b1;
        rst_small = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values, both instances.
        check_reset_pins("full_rst",  f_addr, f_done, f_vclk, f_hs, f_vs, f_blank, f_sync, f_r, f_g, f_b);
        check_reset_pins("small_rst", s_addr, s_done, s_vclk, s_hs, s_vs, s_blank, s_sync, s_r, s_g, s_b);

        // Expected fb_addr after the tick of stage-0 pixel (hc,vc).
        exp_edge_q = '{1, 1603, 1607, 3205, 4479, 4481};
        exp_q      = '{17'd0,   // (0,0)
                       17'd0,   // (1,1)
                       17'd1,   // (3,1)
                       17'd321, // (2,2)
                       17'd639, // (639,2)
                       17'd639};// (640,2): blanked, address held

        // Release both together.
        rst_full  = 1'b0;
        rst_small = 1'b0;
        f_rel     = cyc;
        s_rel     = cyc;
        s_mon     = 1'b1;
        f_hs_p    = 1'b1;
        f_blank_p = 1'b0;

        for (int i = 0; i < 4600; i++) begin
            @(negedge clk);
            k = cyc - f_rel;
            if (f_hs_p && !f_hs)        f_hs_fall_q.push_back(k);
            if (!f_hs_p && f_hs)        f_hs_rise_q.push_back(k);
            if (!f_blank_p && f_blank)  f_blank_rise_q.push_back(k);
            if (f_blank_p && !f_blank)  f_blank_fall_q.push_back(k);
            f_hs_p    = f_hs;
            f_blank_p = f_blank;
            if (exp_edge_q.size() > 0 && k == exp_edge_q[0]) begin
                check_val($sformatf("fb_addr_k%0d", k), f_addr, exp_q[0]);
                void'(exp_edge_q.pop_front());
                void'(exp_q.pop_front());
            end
            case (k)
                1: check_val("vclk_after_first_tick", f_vclk, 0);
                2: check_val("blank_still_low_k2", f_blank, 0);
                3: check_val("blank_high_k3", f_blank, 1);
                7: check_val("rgb_pixel2_addr1", {2'b0, f_r, f_g, f_b}, {2'b0, 10'h000, 10'h000, 10'h3FF});
                23: check_val("rgb_pixel10_addr5", {2'b0, f_r, f_g, f_b}, {2'b0, 10'h3FF, 10'h000, 10'h3FF});
                1403: check_val("rgb_zero_in_hblank", {2'b0, f_r, f_g, f_b}, 0);
                default: ;
            endcase
        end
        check_val("addr_checks_consumed", exp_q.size(), 0);

        // Full-size line timing.
        check_val("hs_fall_count", f_hs_fall_q.size(), 3);
        check_val("blank_rise_count", f_blank_rise_q.size(), 3);
        if (f_hs_fall_q.size() >= 2 && f_hs_rise_q.size() >= 1) begin
            check_val("hs_first_fall", f_hs_fall_q[0], 1315);
            check_val("hs_period", f_hs_fall_q[1] - f_hs_fall_q[0], 1600);
            check_val("hs_low_width", f_hs_rise_q[0] - f_hs_fall_q[0], 192);
        end
        if (f_blank_rise_q.size() >= 1 && f_blank_fall_q.size() >= 1) begin
            check_val("blank_first_rise", f_blank_rise_q[0], 3);
            check_val("blank_high_width", f_blank_fall_q[0] - f_blank_rise_q[0], 1280);
        end

        // Small-instance frame timing.
        check_val("s_fd_count", s_fd_rise_q.size(), 7);
        check_val("s_fd_width", s_fd_high, s_fd_rise_q.size());
        if (s_vs_fall_q.size() >= 2 && s_vs_rise_q.size() >= 1 && s_fd_rise_q.size() >= 2) begin
            check_val("s_vs_first_fall", s_vs_fall_q[0], 483);
            check_val("s_vs_period", s_vs_fall_q[1] - s_vs_fall_q[0], 672);
            check_val("s_vs_low_width", s_vs_rise_q[0] - s_vs_fall_q[0], 96);
            check_val("s_fd_first", s_fd_rise_q[0], 369);
            check_val("s_fd_period", s_fd_rise_q[1] - s_fd_rise_q[0], 672);
        end

        // Mid-frame reset of the small instance while VS is low.
        s_mon = 1'b0;
        for (int i = 0; i < 800 && s_vs !== 1'b0; i++) @(negedge clk);
        check_val("s_vs_low_before_reset", s_vs, 0);
        @(posedge clk);
        #2 rst_small = 1'b1;
        #1 check_reset_pins("small_midrst", s_addr, s_done, s_vclk, s_hs, s_vs, s_blank, s_sync, s_r, s_g, s_b);
        repeat (3) @(negedge clk);
        check_reset_pins("small_hold", s_addr, s_done, s_vclk, s_hs, s_vs, s_blank, s_sync, s_r, s_g, s_b);

        s_vs_fall_q.delete();
        s_vs_rise_q.delete();
        s_fd_rise_q.delete();
        s_blank_rise_q.delete();
        rst_small = 1'b0;
        s_rel     = cyc;
        s_mon     = 1'b1;
        repeat (700) @(negedge clk);
        s_mon = 1'b0;

        check_val("s2_blank_rise_count", s_blank_rise_q.size() > 0, 1);
        check_val("s2_vs_fall_count", s_vs_fall_q.size(), 1);
        if (s_blank_rise_q.size() >= 1 && s_vs_fall_q.size() >= 1) begin
            check_val("s2_blank_first_rise", s_blank_rise_q[0], 3);
            check_val("s2_vs_after_first_pixel", s_vs_fall_q[0] - s_blank_rise_q[0], (S_VV + S_VF) * S_HT * 2);
        end
        check_val("s2_fd_count", s_fd_rise_q.size(), 1);

        // Whole-run pixel model on the small instance.
        check_val("s_samples_present", s_samples > 4000, 1);
        check_val("s_stream_mismatches", s_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
